process_element_mac_pipe: RTL and testbench

PROCESS_ELEMENT_MAC_PIPE -- requirements
Module: process_element_mac_pipe

---
 rtl/process_element_mac_pipe_if.sv | 44 ++++
 rtl/process_element_mac_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_process_element_mac_pipe.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/process_element_mac_pipe_if.sv
// Operand/result bundle for process_element_mac_pipe.
//   master : drives in_valid, in_last, din0, din1; observes the result signals.
//   slave  : the MAC pipe; consumes operands, drives out_valid, dout, out_count, out_ovf.
// Widths must match the parameters of the process_element_mac_pipe instance using it.
interface process_element_mac_pipe_if #(
  parameter int unsigned A_WIDTH   = 9,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 16
);

  logic                        in_valid;
  logic                        in_last;
  logic signed [A_WIDTH-1:0]   din0;
  logic signed [B_WIDTH-1:0]   din1;

  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] dout;
  logic [CNT_WIDTH-1:0]        out_count;
  logic                        out_ovf;

  modport master (
    output in_valid,
    output in_last,
    output din0,
    output din1,
    input  out_valid,
    input  dout,
    input  out_count,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  din0,
    input  din1,
    output out_valid,
    output dout,
    output out_count,
    output out_ovf
  );

endinterface

// File: rtl/process_element_mac_pipe.sv
// Pipelined signed multiply-accumulate processing element.
//
// Operand pairs (din0 x din1) enter at up to one per ce-enabled cycle. Each pair is
// multiplied at full precision through MUL_STAGE register stages, then summed into an
// ACC_WIDTH accumulator. in_last closes a group: the group sum is arithmetically shifted
// right by SHIFT, saturated or truncated to OUT_WIDTH and presented with the term count
// and an overflow flag one cycle later.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset; wins over ce
//   ce     : global clock enable; every register holds while low
//   bus    : slave modport carrying in_valid/in_last/din0/din1 in and
//            out_valid/dout/out_count/out_ovf out
//
// Latency: the result of a group appears MUL_STAGE+1 ce-enabled cycles after the cycle
// that captured its last pair.
module process_element_mac_pipe #(
  parameter int unsigned A_WIDTH   = 9,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned MUL_STAGE = 4,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned SATURATE  = 1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  process_element_mac_pipe_if.slave bus
);

  localparam int unsigned P_WIDTH  = A_WIDTH + B_WIDTH;
  // Bits of the shifted accumulator that must all equal the sign bit for the value to fit.
  localparam int unsigned HI_WIDTH = ACC_WIDTH - OUT_WIDTH + 1;

  typedef enum logic [0:0] {
    StStart,
    StAccum
  } state_e;

  // ---------------------------------------------------------------------------------------
  // Multiplier pipeline
  // Stage 0 holds the captured operands; stages 1..MUL_STAGE-1 hold the product.
  // vld_q/lst_q[k] tag the data sitting in stage k.
  // ---------------------------------------------------------------------------------------
  logic signed [A_WIDTH-1:0] a_q;
  logic signed [B_WIDTH-1:0] b_q;
  logic [MUL_STAGE-1:0]      vld_q;
  logic [MUL_STAGE-1:0]      lst_q;
  logic signed [P_WIDTH-1:0] prod_q [MUL_STAGE-1];
  logic [P_WIDTH-1:0]        mul_raw;

  // Operands sign-extended to the full product width: the modulo-2^P_WIDTH product is
  // then exactly the signed product, which always fits in P_WIDTH bits.
  assign mul_raw = {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q} * {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      lst_q <= '0;
      for (int i = 0; i < int'(MUL_STAGE) - 1; i++) begin
        prod_q[i] <= '0;
      end
    end else if (ce) begin
      a_q       <= bus.din0;
      b_q       <= bus.din1;
      vld_q     <= {vld_q[MUL_STAGE-2:0], bus.in_valid};
      // A last marker without a valid pair carries no meaning; drop it at the door.
      lst_q     <= {lst_q[MUL_STAGE-2:0], bus.in_valid & bus.in_last};
      prod_q[0] <= $signed(mul_raw);
      for (int i = 1; i < int'(MUL_STAGE) - 1; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  logic                        p_valid;
  logic                        p_last;
  logic signed [P_WIDTH-1:0]   p_tail;
  logic signed [ACC_WIDTH-1:0] p_ext;

  assign p_valid = vld_q[MUL_STAGE-1];
  assign p_last  = lst_q[MUL_STAGE-1];
  assign p_tail  = prod_q[MUL_STAGE-2];
  assign p_ext   = ACC_WIDTH'(p_tail);

  // ---------------------------------------------------------------------------------------
  // Accumulator FSM
  // ---------------------------------------------------------------------------------------
  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        gov_q, gov_d;   // sticky group overflow
  logic                        done_q, done_d; // acc/cnt/gov hold a finished group

  logic signed [ACC_WIDTH-1:0] sum;
  logic                        sum_ovf;
  logic [CNT_WIDTH-1:0]        cnt_inc;

  assign sum     = acc_q + p_ext;
  // Signed overflow: both addends share a sign and the result's sign differs from it.
  assign sum_ovf = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gov_d   = gov_q;
    done_d  = 1'b0;
    unique case (state_q)
      StStart: begin
        if (p_valid) begin
          acc_d   = p_ext;
          cnt_d   = CNT_WIDTH'(1);
          gov_d   = 1'b0;
          done_d  = p_last;
          state_d = p_last ? StStart : StAccum;
        end
      end
      StAccum: begin
        if (p_valid) begin
          acc_d  = sum;
          cnt_d  = cnt_inc;
          gov_d  = gov_q | sum_ovf;
          done_d = p_last;
          if (p_last) begin
            state_d = StStart;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StStart;
      acc_q   <= '0;
      cnt_q   <= '0;
      gov_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gov_q   <= gov_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Output stage: shift, range check, saturate/truncate, register
  // ---------------------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [HI_WIDTH-1:0]         hi_bits;
  logic                        fits;
  logic                        sat_evt;
  logic signed [OUT_WIDTH-1:0] res;

  assign shifted = acc_q >>> SHIFT;
  assign hi_bits = shifted[ACC_WIDTH-1:OUT_WIDTH-1];
  assign fits    = (&hi_bits) | ~(|hi_bits);

  always_comb begin
    sat_evt = 1'b0;
    res     = shifted[OUT_WIDTH-1:0];
    if (!fits && (SATURATE != 0)) begin
      sat_evt = 1'b1;
      res     = shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] dout_q;
  logic [CNT_WIDTH-1:0]        out_count_q;
  logic                        out_ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (ce) begin
      out_valid_q <= done_q;
      // Result fields only change when a new group completes.
      if (done_q) begin
        dout_q      <= res;
        out_count_q <= cnt_q;
        out_ovf_q   <= gov_q | sat_evt;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_process_element_mac_pipe.sv
// Self-checking bench for process_element_mac_pipe. Three instances share one stimulus:
// defaults, SATURATE=0 and SHIFT=4. A group-level reference model predicts each result and
// the ce-enabled cycle it must appear on; every cycle all outputs are compared.
module tb_process_element_mac_pipe;

  localparam longint AccMax = 64'sd2147483647;
  localparam longint AccMin = -64'sd2147483648;
  localparam int unsigned Lat = 5;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  logic in_valid;
  logic in_last;
  logic signed [8:0]  din0;
  logic signed [15:0] din1;

  always #5 clk = ~clk;

  process_element_mac_pipe_if bus_m ();
  process_element_mac_pipe_if bus_n ();
  process_element_mac_pipe_if bus_s ();

  assign bus_m.in_valid = in_valid;
  assign bus_m.in_last  = in_last;
  assign bus_m.din0     = din0;
  assign bus_m.din1     = din1;
  assign bus_n.in_valid = in_valid;
  assign bus_n.in_last  = in_last;
  assign bus_n.din0     = din0;
  assign bus_n.din1     = din1;
  assign bus_s.in_valid = in_valid;
  assign bus_s.in_last  = in_last;
  assign bus_s.din0     = din0;
  assign bus_s.din1     = din1;

  process_element_mac_pipe u_dut_m (.clk(clk), .reset(reset), .ce(ce), .bus(bus_m));
  process_element_mac_pipe #(.SATURATE(0)) u_dut_n (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus_n)
  );
  process_element_mac_pipe #(.SHIFT(4)) u_dut_s (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus_s)
  );

  // Reference model ------------------------------------------------------------------------
  typedef struct {
    int unsigned due;   // ce-enabled cycle number on which out_valid must be seen
    logic [47:0] d;     // dout for configs 0..2
    logic [2:0]  o;     // out_ovf for configs 0..2
    logic [15:0] c;
  } res_t;

  int   cfg_shift [3] = '{0, 0, 4};
  bit   cfg_sat   [3] = '{1'b1, 1'b0, 1'b1};

  res_t        exp_q[$];
  longint      m_acc;
  int unsigned m_cnt;
  bit          m_ovf;
  bit          m_in_grp;
  int unsigned ce_cnt;
  logic [47:0] held_d;
  logic [2:0]  held_o;
  logic [15:0] held_c;
  int          n_cmp;
  int          n_fail;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void close_group();
    res_t r;
    r.due = ce_cnt + Lat;
    r.c   = m_cnt[15:0];
    for (int i = 0; i < 3; i++) begin
      longint sh;
      bit     oor;
      logic [15:0] v;
      sh  = m_acc >>> cfg_shift[i];
      oor = (sh > 64'sd32767) || (sh < -64'sd32768);
      if (cfg_sat[i] && oor) v = (sh < 0) ? 16'h8000 : 16'h7fff;
      else                   v = sh[15:0];
      r.d[16*i +: 16] = v;
      r.o[i]          = m_ovf | (cfg_sat[i] & oor);
    end
    exp_q.push_back(r);
  endfunction

  function automatic void take_pair(int a, int b, bit l);
    longint p;
    longint t;
    p = longint'(a) * longint'(b);
    if (!m_in_grp) begin
      m_acc = p;
      m_cnt = 1;
      m_ovf = 1'b0;
    end else begin
      t = m_acc + p;
      if (t > AccMax || t < AccMin) m_ovf = 1'b1;
      m_acc = longint'(int'(t));
      if (m_cnt < 65535) m_cnt++;
    end
    m_in_grp = !l;
    if (l) close_group();
  endfunction

  // One clock: drive, advance model, then compare every output of every instance.
  task automatic step(bit c, bit r, bit v, bit l, int a, int b);
    bit exp_v;
    ce       = c;
    reset    = r;
    in_valid = v;
    in_last  = l;
    din0     = 9'(a);
    din1     = 16'(b);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_in_grp = 1'b0;
      held_d   = '0;
      held_o   = '0;
      held_c   = '0;
    end else if (c) begin
      ce_cnt++;
      while (exp_q.size() > 0 && exp_q[0].due < ce_cnt) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].due == ce_cnt) begin
        held_d = exp_q[0].d;
        held_o = exp_q[0].o;
        held_c = exp_q[0].c;
      end
      if (v) take_pair(a, b, l);
    end
    #1;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == ce_cnt);
    check("m_valid", 16'(bus_m.out_valid), 16'(exp_v));
    check("n_valid", 16'(bus_n.out_valid), 16'(exp_v));
    check("s_valid", 16'(bus_s.out_valid), 16'(exp_v));
    check("m_dout",  bus_m.dout, held_d[15:0]);
    check("n_dout",  bus_n.dout, held_d[31:16]);
    check("s_dout",  bus_s.dout, held_d[47:32]);
    check("m_ovf",   16'(bus_m.out_ovf), 16'(held_o[0]));
    check("n_ovf",   16'(bus_n.out_ovf), 16'(held_o[1]));
    check("s_ovf",   16'(bus_s.out_ovf), 16'(held_o[2]));
    check("m_count", bus_m.out_count, held_c);
    check("n_count", bus_n.out_count, held_c);
    check("s_count", bus_s.out_count, held_c);
  endtask

  // ce-enabled cycles with no valid pair; in_last toggled randomly to show it is ignored.
  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 65535)) - 32768);
    end
  endtask

  function automatic int rnd_a();
    unsigned_pick: begin end
    if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) != 0) ? -256 : 255;
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  function automatic int rnd_b();
    if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) != 0) ? -32768 : 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    ce_cnt   = 0;
    m_in_grp = 1'b0;
    m_acc    = 0;
    m_cnt    = 0;
    m_ovf    = 1'b0;
    held_d   = '0;
    held_o   = '0;
    held_c   = '0;
    ce       = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    din0     = '0;
    din1     = '0;

    // Reset, including one edge with ce low.
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5, 5);
    idle(2);

    // Three-term group.
    step(1'b1, 1'b0, 1'b1, 1'b0, 3, 100);
    step(1'b1, 1'b0, 1'b1, 1'b0, -2, 50);
    step(1'b1, 1'b0, 1'b1, 1'b1, 5, -7);
    idle(7);
    check("grp3_dout", bus_m.dout, 16'd165);
    check("grp3_count", bus_m.out_count, 16'd3);
    check("grp3_ovf", 16'(bus_m.out_ovf), 16'd0);

    // Single extreme pair: saturation versus truncation.
    step(1'b1, 1'b0, 1'b1, 1'b1, -256, -32768);
    idle(7);
    check("sat_dout", bus_m.dout, 16'h7fff);
    check("sat_ovf", 16'(bus_m.out_ovf), 16'd1);
    check("trunc_dout", bus_n.dout, 16'h0000);
    check("trunc_ovf", 16'(bus_n.out_ovf), 16'd0);

    // Same three-term group with a ce gap (valid data offered but not captured).
    step(1'b1, 1'b0, 1'b1, 1'b0, 3, 100);
    step(1'b1, 1'b0, 1'b1, 1'b0, -2, 50);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 9, 9);
    step(1'b1, 1'b0, 1'b1, 1'b1, 5, -7);
    idle(Lat);
    check("gap_valid_seen", 16'(bus_m.out_valid), 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("gap_valid_held", 16'(bus_m.out_valid), 16'd1);
    idle(2);
    check("gap_dout", bus_m.dout, 16'd165);

    // Reset mid-group discards it.
    step(1'b1, 1'b0, 1'b1, 1'b0, 7, 7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8, 8);
    step(1'b1, 1'b1, 1'b1, 1'b1, 9, 9);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1, 1);
    idle(8);
    check("rst_dout", bus_m.dout, 16'd1);
    check("rst_count", bus_m.out_count, 16'd1);

    // Back-to-back single-term groups.
    step(1'b1, 1'b0, 1'b1, 1'b1, 2, 3);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4, 5);
    idle(Lat - 1);
    check("b2b_first", bus_m.dout, 16'd6);
    idle(1);
    check("b2b_second", bus_m.dout, 16'd20);
    idle(3);

    // SHIFT=4 rounding toward minus infinity.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1, -1);
    idle(7);
    check("shift_neg", bus_s.dout, 16'hffff);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16, 1);
    idle(7);
    check("shift_pos", bus_s.dout, 16'd1);

    // Long group that overflows the accumulator.
    for (int i = 0; i < 299; i++) step(1'b1, 1'b0, 1'b1, 1'b0, -256, -32768);
    step(1'b1, 1'b0, 1'b1, 1'b1, -256, -32768);
    idle(7);
    check("acc_ovf_flag", 16'(bus_n.out_ovf), 16'd1);
    check("acc_ovf_count", bus_n.out_count, 16'd300);

    // Randomized traffic with ce gaps, bubbles and occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           rnd_a(), rnd_b());
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
